// File: rtl/window_gen_3x3_if.sv
// ---------------------------------------------------------------------------
// window_gen_3x3_if
// Pixel-stream / window bus for window_gen_3x3.
//
// Optional feature macro: WINDOW_FRAME_DONE_EN (adds frame_done).
//
// Signals:
//   in_valid   : pixel strobe. The pixel is accepted on every edge where it is 1.
//   in_pixel   : raster-order unsigned pixel, in_width bits.
//   window     : packed 3x3 window. Element i occupies [(i+1)*in_width-1 : i*in_width].
//   out_valid  : window holds a complete 3x3 neighbourhood from the current frame.
//   frame_done : one-cycle pulse after the last pixel of a frame (macro only).
//
// Modports:
//   master : pixel source and window consumer.
//   slave  : the window generator.
// ---------------------------------------------------------------------------
interface window_gen_3x3_if #(
  parameter int in_width = 8
);
  logic                    in_valid;
  logic [in_width-1:0]     in_pixel;
  logic [9*in_width-1:0]   window;
  logic                    out_valid;
`ifdef WINDOW_FRAME_DONE_EN
  logic                    frame_done;
`endif

  modport master (
    output in_valid,
    output in_pixel,
    input  window,
`ifdef WINDOW_FRAME_DONE_EN
    input  frame_done,
`endif
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  in_pixel,
    output window,
`ifdef WINDOW_FRAME_DONE_EN
    output frame_done,
`endif
    output out_valid
  );
endinterface

// File: rtl/window_gen_3x3.sv
// ---------------------------------------------------------------------------
// window_gen_3x3
// Turns a raster-order pixel stream into a sliding 3x3 neighbourhood window,
// using two line buffers that hold the previous two rows.
//
// Optional feature macro: WINDOW_FRAME_DONE_EN
//   defined   -> bus.frame_done pulses after the last pixel of each frame
//   undefined -> frame_done and its logic do not exist
//
// Parameters:
//   in_width : bits per pixel
//   IMG_W    : pixels per row (>= 3)
//   IMG_H    : rows per frame (>= 3)
//
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset
//   bus : window_gen_3x3_if slave (in_valid, in_pixel, window, out_valid,
//         frame_done when enabled)
// ---------------------------------------------------------------------------
module window_gen_3x3 #(
  parameter int in_width = 8,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8
) (
  input  logic            clk,
  input  logic            rst,
  window_gen_3x3_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int WW = 9 * in_width;

  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [RW-1:0] ROW_TWO = RW'(2);

  // Position of the next pixel to be accepted.
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Line buffers: lb0 holds the previous row, lb1 the row before that.
  logic [in_width-1:0] lb0_q [IMG_W];
  logic [in_width-1:0] lb1_q [IMG_W];

  logic [WW-1:0] win_q, win_d;
  logic          valid_q, valid_d;

`ifdef WINDOW_FRAME_DONE_EN
  logic          fdone_q, fdone_d;
`endif

  logic lastCol;
  logic lastRow;

  assign lastCol = (col_q == COL_MAX);
  assign lastRow = (row_q == ROW_MAX);

  // Next-state for the raster counters and the window. On each accepted pixel
  // every window row slides one column left and a new right column is loaded
  // from lb1 (top), lb0 (middle) and the incoming pixel (bottom). The window
  // is only flagged valid when all three rows and columns belong to the
  // current row span of the current frame, which keeps stale line-buffer
  // data from row or frame wraps from ever being reported.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
`ifdef WINDOW_FRAME_DONE_EN
    fdone_d = 1'b0;
`endif
    if (bus.in_valid) begin
      if (lastCol) begin
        col_d = '0;
        row_d = lastRow ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      for (int r = 0; r < 3; r++) begin
        win_d[(3*r)*in_width   +: in_width] = win_q[(3*r+1)*in_width +: in_width];
        win_d[(3*r+1)*in_width +: in_width] = win_q[(3*r+2)*in_width +: in_width];
      end
      win_d[2*in_width +: in_width] = lb1_q[col_q];
      win_d[5*in_width +: in_width] = lb0_q[col_q];
      win_d[8*in_width +: in_width] = bus.in_pixel;

      valid_d = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
`ifdef WINDOW_FRAME_DONE_EN
      fdone_d = lastRow && lastCol;
`endif
    end
  end

  // Control and window registers; reset abandons any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
`ifdef WINDOW_FRAME_DONE_EN
      fdone_q <= 1'b0;
`endif
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
`ifdef WINDOW_FRAME_DONE_EN
      fdone_q <= fdone_d;
`endif
    end
  end

  // Line buffers carry no reset: their contents only reach a valid window
  // after two full rows of the current frame have overwritten them.
  always_ff @(posedge clk) begin
    if (!rst && bus.in_valid) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= bus.in_pixel;
    end
  end

  assign bus.window    = win_q;
  assign bus.out_valid = valid_q;
`ifdef WINDOW_FRAME_DONE_EN
  assign bus.frame_done = fdone_q;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// ---------------------------------------------------------------------------
// tb_window_gen_3x3
// Scoreboard bench for window_gen_3x3 (IMG_W=4, IMG_H=4, in_width=8).
// The driver keeps a picture of the current frame as a 2-D array and, for
// every pixel that completes a 3x3 neighbourhood, queues the expected window
// and the cycle it must appear in. A monitor on the falling edge pops and
// compares whenever out_valid is seen, or when an expected window is late.
// ---------------------------------------------------------------------------
module tb_window_gen_3x3;

  localparam int PW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int WW = 9 * PW;

  typedef struct {
    logic [WW-1:0] win;
    int            cyc;
    bit            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  window_gen_3x3_if #(.in_width(PW)) bus ();

  window_gen_3x3 #(
    .in_width(PW),
    .IMG_W   (W),
    .IMG_H   (H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  exp_t          scoreQ [$];
  logic [WW-1:0] gotLog [$];
  logic [WW-1:0] refLog [$];

  logic [PW-1:0] img [H][W];
  int            mIdx = 0;

  exp_t e;
  bit   fdExp;

  // Single comparison point used by both the driver and the monitor.
  task automatic checkOutput(input string name, input logic [WW-1:0] act,
                             input logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of input; for an accepted pixel, record it in the frame
  // picture and queue the window it completes, if any.
  task automatic applyStimulus(input bit valid, input logic [PW-1:0] pix);
    int r;
    int c;
    exp_t x;
    @(posedge clk);
    #1;
    bus.in_valid = valid;
    bus.in_pixel = pix;
    if (valid) begin
      r = mIdx / W;
      c = mIdx % W;
      img[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        x.win = '0;
        for (int rr = 0; rr < 3; rr++)
          for (int kk = 0; kk < 3; kk++)
            x.win[(3*rr+kk)*PW +: PW] = img[r-2+rr][c-2+kk];
        x.cyc  = cyc + 1;
        x.last = (mIdx == W*H - 1);
        scoreQ.push_back(x);
      end
      mIdx = (mIdx + 1) % (W*H);
    end
  endtask

  // Reset for n cycles with in_valid held high to show reset wins.
  task automatic doReset(input int n);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'hA5;
    repeat (n) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", {71'd0, bus.out_valid}, '0);
    checkOutput("reset_window", bus.window, '0);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    mIdx         = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'($urandom));
  endtask

  task automatic sendFrame(input int base, input bit bubbles);
    for (int p = 0; p < W*H; p++) begin
      applyStimulus(1'b1, 8'(base + p));
      if (bubbles) applyStimulus(1'b0, 8'($urandom));
    end
  endtask

  // Window of a frame whose pixels are base, base+1, ... in raster order.
  function automatic logic [WW-1:0] rampWin(input int base, input int r0, input int c0);
    logic [WW-1:0] w;
    w = '0;
    for (int rr = 0; rr < 3; rr++)
      for (int kk = 0; kk < 3; kk++)
        w[(3*rr+kk)*PW +: PW] = 8'(base + (r0+rr)*W + (c0+kk));
    return w;
  endfunction

  function automatic int sumWin(input logic [WW-1:0] w);
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) s += int'(w[i*PW +: PW]);
    return s;
  endfunction

  // Monitor: compare on every out_valid, and flag windows that never came.
  always @(negedge clk) begin
    fdExp = 1'b0;
    if (bus.out_valid) begin
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected_window", {71'd0, bus.out_valid}, '0);
      end else begin
        e = scoreQ.pop_front();
        checkOutput("window", bus.window, e.win);
        checkOutput("window_cycle", WW'(cyc), WW'(e.cyc));
        gotLog.push_back(bus.window);
        fdExp = e.last;
      end
    end else if (scoreQ.size() > 0 && scoreQ[0].cyc <= cyc) begin
      e = scoreQ.pop_front();
      checkOutput("missing_window", {71'd0, bus.out_valid}, WW'(1));
    end
`ifdef WINDOW_FRAME_DONE_EN
    checkOutput("frame_done", {71'd0, bus.frame_done}, {71'd0, fdExp});
`endif
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;

    doReset(2);

    // Continuous ramp frame 1..16.
    gotLog.delete();
    sendFrame(1, 1'b0);
    idle(3);
    checkOutput("t1_pulses", WW'(gotLog.size()), WW'(4));
    checkOutput("t1_first", gotLog[0], rampWin(1, 0, 0));
    checkOutput("t1_last", gotLog[3], rampWin(1, 1, 1));
    checkOutput("t1_sum_first", WW'(sumWin(gotLog[0])), WW'(54));
    checkOutput("t1_sum_last", WW'(sumWin(gotLog[3])), WW'(99));
    refLog = gotLog;

    // Same frame with a bubble after every pixel.
    gotLog.delete();
    sendFrame(1, 1'b1);
    idle(3);
    checkOutput("t2_pulses", WW'(gotLog.size()), WW'(4));
    for (int i = 0; i < 4; i++) checkOutput("t2_same", gotLog[i], refLog[i]);

    // Two frames back-to-back.
    gotLog.delete();
    sendFrame(1, 1'b0);
    sendFrame(101, 1'b0);
    idle(3);
    checkOutput("t3_pulses", WW'(gotLog.size()), WW'(8));
    checkOutput("t3_fifth", gotLog[4], rampWin(101, 0, 0));
    checkOutput("t3_eighth", gotLog[7], rampWin(101, 1, 1));

    // Reset after 7 pixels, then a full frame.
    gotLog.delete();
    for (int p = 1; p <= 7; p++) applyStimulus(1'b1, 8'(p));
    doReset(2);
    sendFrame(1, 1'b0);
    idle(3);
    checkOutput("t4_pulses", WW'(gotLog.size()), WW'(4));
    checkOutput("t4_first", gotLog[0], refLog[0]);
    checkOutput("t4_last", gotLog[3], refLog[3]);

    // Random pixels, random bubbles, occasional mid-frame reset.
    for (int f = 0; f < 12; f++) begin
      int cut;
      cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W*H-1)) : -1;
      for (int p = 0; p < W*H; p++) begin
        if (p == cut) doReset(int'($urandom_range(1, 2)));
        applyStimulus(1'b1, 8'($urandom));
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
      end
    end
    idle(4);
    checkOutput("queue_drained", WW'(scoreQ.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 SHALL have parameter in_width, default 8, bits per pixel.
REQ-002 SHALL have parameter IMG_W, default 8, pixels per row (>=3).
REQ-003 SHALL have parameter IMG_H, default 8, rows per frame (>=3).
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  pixel strobe; pixel accepted on any rising edge where in_valid=1.
REQ-007 SHALL have port in_pixel  input  in_width  raster-order pixel, unsigned.
REQ-008 SHALL have port window  output  9*in_width  packed 3x3 window, element i at bits [(i+1)*in_width-1 : i*in_width]; directly consumable by the downstream 9-input adder tree.
REQ-009 SHALL have port out_valid  output  1  window holds a complete, valid 3x3 neighbourhood.
REQ-010 SHALL have port frame_done  output  1  present only per REQ-027.

Function
REQ-011 SHALL keep col counter (0..IMG_W-1) and row counter (0..IMG_H-1) giving the position of the next pixel to be accepted.
REQ-012 On accept, col SHALL increment; at col=IMG_W-1 it SHALL wrap to 0 and row increments; at row=IMG_H-1 and col=IMG_W-1 both SHALL wrap to 0 (next frame starts).
REQ-013 SHALL hold two line buffers LB0 (previous row), LB1 (row before that), each IMG_W x in_width, indexed by col.
REQ-014 On accept at column c: LB1[c]<=LB0[c], LB0[c]<=in_pixel; the 3x3 window register SHALL shift left one column, new right column = {LB1[c] top, LB0[c] middle, in_pixel bottom} (old values of LB0/LB1).
REQ-015 Element index i=3*r+k, r=0 top (oldest) row, r=2 bottom row; k=0 leftmost (oldest) column, k=2 newest; element 4 is the centre pixel.
REQ-016 out_valid SHALL be 1 in the cycle after accepting pixel (row,col) with row>=2 and col>=2, else 0; latency accept->window = 1 clock.
REQ-017 When out_valid=1, window SHALL contain pixels rows row-2..row, cols col-2..col of the current frame only.
REQ-018 in_valid=0: counters, line buffers, window SHALL hold; out_valid SHALL be 0 in the following cycle.
REQ-019 No backpressure: every in_valid=1 cycle is accepted; out_valid is a single-cycle pulse per qualifying pixel.
REQ-020 Windows spanning a row wrap (col<2) or frame wrap (row<2 of new frame) SHALL never raise out_valid, even if stale line-buffer data is present.
REQ-021 Back-to-back frames with no idle cycle SHALL be supported; first valid window of frame N+1 at its pixel (2,2).

Reset
REQ-022 rst=1 at a rising edge SHALL set row=0, col=0, out_valid=0, window=0, frame_done=0; overrides in_valid in that cycle.
REQ-023 Line buffer contents need not be reset; REQ-020 guarantees they are never exposed.
REQ-024 Reset mid-frame SHALL abandon the frame; first pixel accepted after rst deasserts is (0,0).

Configuration
REQ-025 Macro WINDOW_FRAME_DONE_EN controls frame_done.
REQ-026 Without the macro: port frame_done and its logic SHALL not exist.
REQ-027 With the macro: frame_done SHALL pulse 1 for exactly one cycle, the cycle after accepting pixel (IMG_H-1, IMG_W-1), coincident with the last out_valid of the frame; 0 otherwise.

Verification (IMG_W=4, IMG_H=4, in_width=8 unless stated)
REQ-028 Continuous frame pixels 1..16 -> exactly 4 out_valid pulses; first window = {1,2,3,5,6,7,9,10,11} (i=0..8), sum 54; last = {6,7,8,10,11,12,14,15,16}, sum 99.
REQ-029 Same frame with in_valid=0 bubbles inserted after every pixel -> identical 4 windows in order, out_valid never asserted during bubbles.
REQ-030 Two frames back-to-back (1..16 then 101..116) -> 8 windows; 5th window = {101,102,103,105,106,107,109,110,111}; no valid window mixing frames.
REQ-031 rst pulsed after 7 pixels, then 1..16 sent -> out_valid low during/after reset until 11th pixel accepted; windows equal REQ-028.
REQ-032 With WINDOW_FRAME_DONE_EN, REQ-028 stimulus -> frame_done high exactly one cycle, same cycle as 4th out_valid; without macro, build elaborates with no frame_done port.
